// File: rtl/cpu_fetch_pkg.sv
// Shared types for the instruction fetch sequencer: queue entry layout,
// FSM state encoding and the canonical RV32I NOP encoding.
package cpu_fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries. A flush empties
// the queue and wins over a simultaneous push or pop.
module fetch_queue
    import cpu_fetch_pkg::*;
#(
    parameter int FQ_DEPTH = 2,
    localparam int CW = $clog2(FQ_DEPTH + 1),
    localparam int PW = $clog2(FQ_DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  fetch_entry_t  entry,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t  mem [FQ_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer and occupancy bookkeeping; flush clears everything.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; contents need no reset since the head is gated by count.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem[wr_ptr] <= entry;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues reads to a 16-word
// synchronous ROM, absorbs its one-cycle latency in a fetch queue and hands
// instructions to decode over valid/ready. Redirects flush and refetch.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer
    import cpu_fetch_pkg::*;
#(
    parameter int          ROM_ENTRIES    = 16,
    parameter int          ROM_ADDR_WIDTH = 4,
    parameter int          FQ_DEPTH       = 2,
    parameter logic [31:0] BOOT_PC        = 32'h0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [31:0]               rom_instruction,
    output logic                      fetch_valid,
    input  logic                      fetch_ready,
    output logic [31:0]               fetch_instr,
    output logic [31:0]               fetch_pc,
    output logic                      halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]               perf_fetched,
    output logic [31:0]               perf_stall,
    output logic [31:0]               perf_redirect
`endif
);

    localparam int          CW       = $clog2(FQ_DEPTH + 1);
    localparam logic [31:0] PC_LIMIT = 32'(ROM_ENTRIES * 4);

    fetch_state_t              state;
    fetch_state_t              state_next;
    logic [31:0]               pc;
    logic [31:0]               pc_next;
    logic                      inflight;
    logic [31:0]               inflight_pc;
    logic [ROM_ADDR_WIDTH-1:0] last_addr;
    logic [CW-1:0]             count;
    logic [CW:0]               occupancy;
    fetch_entry_t              head;
    fetch_entry_t              push_entry;
    logic                      pop;
    logic                      push;
    logic                      issue;
    logic                      redirect_take;
    logic [31:0]               redirect_target;
    logic                      unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign redirect_take   = redirect_valid && (state != IDLE);
    assign redirect_target = {redirect_pc[31:2], 2'b00};

    assign fetch_valid = (count != '0);
    assign pop         = fetch_valid && fetch_ready;
    assign occupancy   = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue       = (state == RUN) && !redirect_take && (pc < PC_LIMIT)
                         && (occupancy < (CW+1)'(FQ_DEPTH));

    assign push       = inflight && !redirect_take;
    assign push_entry = {inflight_pc, rom_instruction};

    assign rom_addr    = issue ? pc[ROM_ADDR_WIDTH+1:2] : last_addr;
    assign fetch_pc    = fetch_valid ? head.pc : '0;
    assign fetch_instr = fetch_valid ? head.instr : '0;
    assign halted      = (state == HALT) && (count == '0) && !inflight;

    fetch_queue #(
        .FQ_DEPTH (FQ_DEPTH)
    ) u_queue (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .entry   (push_entry),
        .pop     (pop),
        .flush   (redirect_take),
        .count   (count),
        .head    (head)
    );

    // Next-state and next-PC: redirects dominate, running past the ROM halts.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    pc_next    = BOOT_PC;
                end
            end
            RUN, HALT: begin
                if (redirect_take) begin
                    pc_next    = redirect_target;
                    state_next = (redirect_target >= PC_LIMIT) ? HALT : RUN;
                end else if (state == RUN) begin
                    if (pc >= PC_LIMIT) begin
                        state_next = HALT;
                    end else if (issue) begin
                        pc_next = pc + 32'd4;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, PC and the single in-flight read tag; no issue means no capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= BOOT_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            last_addr   <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                last_addr   <= pc[ROM_ADDR_WIDTH+1:2];
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating event counters for handshakes, stalls and accepted redirects.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched  <= '0;
            perf_stall    <= '0;
            perf_redirect <= '0;
        end else begin
            if (pop && (perf_fetched != 32'hFFFF_FFFF)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (fetch_valid && !fetch_ready && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (redirect_take && (perf_redirect != 32'hFFFF_FFFF)) begin
                perf_redirect <= perf_redirect + 32'd1;
            end
        end
    end
`endif

endmodule
